// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue_pkg
// Description : Shared types and sizing constants for the ALU issue queue:
//               micro-op bundle, PRF write-back broadcast, queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_queue_pkg;

  localparam int ALU_IQ_DEPTH  = 8;
  localparam int ALU_IQ_NUM_WB = 4;
  localparam int ALU_IQ_PREG_W = 7;   // physical register tag width
  localparam int ALU_IQ_XLEN   = 64;  // write-back data width

  typedef struct packed {
    logic                     valid;
    logic [3:0]               opcode;
    logic [5:0]               rob_idx;
    logic                     op0re;
    logic [ALU_IQ_PREG_W-1:0] op0PAddr;
    logic                     op1re;
    logic [ALU_IQ_PREG_W-1:0] op1PAddr;
    logic                     dstwe;
    logic [ALU_IQ_PREG_W-1:0] dstPAddr;
  } UOPBundle;

  typedef struct packed {
    logic                     wen;
    logic [ALU_IQ_PREG_W-1:0] rd;
    logic [ALU_IQ_XLEN-1:0]   wdata;
  } PRFwInfo;

  typedef struct packed {
    UOPBundle uop;
    logic     rdy0;
    logic     rdy1;
    logic     valid;
  } ALUIQEntry;

  // True when a broadcast with write enable targets the given tag.
  function automatic logic preg_hit(input logic wen,
                                    input logic [ALU_IQ_PREG_W-1:0] rd,
                                    input logic [ALU_IQ_PREG_W-1:0] tag);
    return wen && (rd == tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue_if
// Description : Dispatch / write-back / issue bundle of the ALU issue queue.
//               master : dispatch side (drives enq, wb_bus, flush, stall)
//               slave  : the queue (drives enq_ready, issue_uop, count)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_queue_if
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = ALU_IQ_DEPTH,
  parameter int NUM_WB = ALU_IQ_NUM_WB
);

  UOPBundle               enq_uop;
  logic                   enq_op0_rdy;
  logic                   enq_op1_rdy;
  logic                   enq_ready;
  PRFwInfo                wb_bus [NUM_WB];
  logic                   flush;
  logic                   issue_stall;
  UOPBundle               issue_uop;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output enq_uop, enq_op0_rdy, enq_op1_rdy, wb_bus, flush, issue_stall,
    input  enq_ready, issue_uop, count
  );

  modport slave (
    input  enq_uop, enq_op0_rdy, enq_op1_rdy, wb_bus, flush, issue_stall,
    output enq_ready, issue_uop, count
  );

endinterface
`default_nettype wire

// File: rtl/alu_iq_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_iq_select
// Description : Combinational find-first-set over the request vector; the
//               lowest set index (oldest entry) wins.
//   i_req   : per-entry request (valid & rdy0 & rdy1)
//   o_grant : one-hot grant
//   o_idx   : index of the granted entry
//   o_any   : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         i_req,
  output logic [DEPTH-1:0]         o_grant,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_any
);

  localparam int c_IDX_W = $clog2(DEPTH);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = c_IDX_W'(i);
        o_any      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Collapsing out-of-order issue queue for the ALU pipe. Index 0
//               is the oldest entry; the oldest ready entry issues each cycle
//               into a registered output.
//   clk, rst : clock, synchronous active-high reset
//   iq       : alu_issue_queue_if.slave (enqueue, write-back broadcasts,
//              flush, issue_stall, issue_uop, count, enq_ready)
// Build option: define ALU_IQ_BACK2BACK_EN to wake dependents of the selected
//               uop in the select cycle (back-to-back issue via ALU bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = ALU_IQ_DEPTH,
  parameter int NUM_WB = ALU_IQ_NUM_WB
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_queue_if.slave  iq
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;

  ALUIQEntry          r_q [DEPTH];
  logic [c_CNT_W-1:0] r_count;
  UOPBundle           r_issue;

  logic [DEPTH-1:0]         w_req;
  logic [DEPTH-1:0]         w_grant;
  logic [c_IDX_W-1:0]       w_sel_idx;
  logic                     w_any;
  logic                     w_issue;
  logic                     w_enq;
  logic                     w_enq_ready;
  logic [c_CNT_W-1:0]       w_wr_idx;
  UOPBundle                 w_sel_uop;
  ALUIQEntry                w_enq_ent;
  ALUIQEntry                w_woken [DEPTH+1];
  ALUIQEntry                w_q_nxt [DEPTH];
  logic                     w_b2b_wen;
  logic [ALU_IQ_PREG_W-1:0] w_b2b_rd;
  logic                     w_unused_wdata;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_req[i] = r_q[i].valid & r_q[i].rdy0 & r_q[i].rdy1;
    end
  end

  alu_iq_select #(.DEPTH(DEPTH)) u_select (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_sel_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_uop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_sel_uop = r_q[i].uop;
    end
  end

  assign w_enq_ready = (r_count < c_CNT_W'(DEPTH));
  assign w_issue     = w_any & ~iq.issue_stall & ~iq.flush;
  assign w_enq       = iq.enq_uop.valid & w_enq_ready & ~iq.flush;
  // The issuing entry vacates a slot below the tail in the same cycle.
  assign w_wr_idx    = r_count - c_CNT_W'(w_issue);

`ifdef ALU_IQ_BACK2BACK_EN
  assign w_b2b_wen = w_issue & w_sel_uop.dstwe;
  assign w_b2b_rd  = w_sel_uop.dstPAddr;
`else
  assign w_b2b_wen = 1'b0;
  assign w_b2b_rd  = '0;
`endif

  // Wakeup: sticky OR of every broadcast match into the stored ready bits.
  // w_woken[DEPTH] is an empty slot shifted into the top on collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = r_q[i];
      for (int k = 0; k < NUM_WB; k++) begin
        if (preg_hit(iq.wb_bus[k].wen, iq.wb_bus[k].rd, r_q[i].uop.op0PAddr)) w_woken[i].rdy0 = 1'b1;
        if (preg_hit(iq.wb_bus[k].wen, iq.wb_bus[k].rd, r_q[i].uop.op1PAddr)) w_woken[i].rdy1 = 1'b1;
      end
      if (preg_hit(w_b2b_wen, w_b2b_rd, r_q[i].uop.op0PAddr)) w_woken[i].rdy0 = 1'b1;
      if (preg_hit(w_b2b_wen, w_b2b_rd, r_q[i].uop.op1PAddr)) w_woken[i].rdy1 = 1'b1;
    end
    w_woken[DEPTH] = '0;
  end

  // New entry sees same-cycle broadcasts so a racing write-back is not lost.
  always_comb begin
    w_enq_ent       = '0;
    w_enq_ent.uop   = iq.enq_uop;
    w_enq_ent.valid = 1'b1;
    w_enq_ent.rdy0  = ~iq.enq_uop.op0re | iq.enq_op0_rdy
                    | preg_hit(w_b2b_wen, w_b2b_rd, iq.enq_uop.op0PAddr);
    w_enq_ent.rdy1  = ~iq.enq_uop.op1re | iq.enq_op1_rdy
                    | preg_hit(w_b2b_wen, w_b2b_rd, iq.enq_uop.op1PAddr);
    for (int k = 0; k < NUM_WB; k++) begin
      if (preg_hit(iq.wb_bus[k].wen, iq.wb_bus[k].rd, iq.enq_uop.op0PAddr)) w_enq_ent.rdy0 = 1'b1;
      if (preg_hit(iq.wb_bus[k].wen, iq.wb_bus[k].rd, iq.enq_uop.op1PAddr)) w_enq_ent.rdy1 = 1'b1;
    end
  end

  // Collapse: entries at and above the issued index move down by one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (c_IDX_W'(i) >= w_sel_idx)) w_q_nxt[i] = w_woken[i+1];
      else                                       w_q_nxt[i] = w_woken[i];
      if (w_enq && (c_CNT_W'(i) == w_wr_idx))     w_q_nxt[i] = w_enq_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_count <= '0;
      r_issue <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_q_nxt[i];
      r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_issue);
      if (!iq.issue_stall) r_issue <= w_issue ? w_sel_uop : '0;
    end
  end

  assign iq.enq_ready = w_enq_ready;
  assign iq.issue_uop = r_issue;
  assign iq.count     = r_count;

  // Write-back data is carried on the bus but not needed for wakeup.
  always_comb begin
    w_unused_wdata = 1'b0;
    for (int k = 0; k < NUM_WB; k++) w_unused_wdata = w_unused_wdata ^ (^iq.wb_bus[k].wdata);
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Directed self-checking bench for alu_issue_queue. Expected
//               issued uops are queued when driven and compared on issue.
//               Honours ALU_IQ_BACK2BACK_EN for the dependent-issue case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int c_DEPTH  = 8;
  localparam int c_NUM_WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(c_DEPTH), .NUM_WB(c_NUM_WB)) iq ();

  alu_issue_queue #(.DEPTH(c_DEPTH), .NUM_WB(c_NUM_WB)) dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq.slave)
  );

  int       n_vec = 0;
  int       n_err = 0;
  UOPBundle sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic UOPBundle mk(input logic [5:0] rob, input logic re0, input logic [6:0] p0,
                                  input logic re1, input logic [6:0] p1,
                                  input logic dwe, input logic [6:0] dst);
    UOPBundle u;
    u          = '0;
    u.valid    = 1'b1;
    u.opcode   = rob[3:0];
    u.rob_idx  = rob;
    u.op0re    = re0;
    u.op0PAddr = p0;
    u.op1re    = re1;
    u.op1PAddr = p1;
    u.dstwe    = dwe;
    u.dstPAddr = dst;
    return u;
  endfunction

  task automatic enq(input UOPBundle u, input logic r0, input logic r1);
    iq.enq_uop     = u;
    iq.enq_op0_rdy = r0;
    iq.enq_op1_rdy = r1;
  endtask

  task automatic no_enq();
    iq.enq_uop     = '0;
    iq.enq_op0_rdy = 1'b0;
    iq.enq_op1_rdy = 1'b0;
  endtask

  task automatic wb_set(input int k, input logic [6:0] rd);
    iq.wb_bus[k]       = '0;
    iq.wb_bus[k].wen   = 1'b1;
    iq.wb_bus[k].rd    = rd;
    iq.wb_bus[k].wdata = 64'hdead_0000 | 64'(rd);
  endtask

  task automatic wb_clr();
    for (int k = 0; k < c_NUM_WB; k++) iq.wb_bus[k] = '0;
  endtask

  // One clock: sample #1 after the edge; a fresh issue is checked against
  // the scoreboard, a stalled output must hold its previous value.
  task automatic step();
    logic     was_stall, was_flush, was_rst;
    UOPBundle prev, exp;
    was_stall = iq.issue_stall;
    was_flush = iq.flush;
    was_rst   = rst;
    prev      = iq.issue_uop;
    @(posedge clk);
    #1;
    if (!was_rst && !was_flush) begin
      if (was_stall) begin
        chk("stall_hold", 64'(iq.issue_uop), 64'(prev));
      end else if (iq.issue_uop.valid) begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_issue observed rob=%0d expected none", iq.issue_uop.rob_idx);
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("issue_uop", 64'(iq.issue_uop), 64'(exp));
        end
      end
    end
  endtask

  initial begin
    UOPBundle u, a, b, p, d;
    UOPBundle fill [8];

    no_enq();
    wb_clr();
    iq.flush       = 1'b0;
    iq.issue_stall = 1'b0;
    rst            = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 64'(iq.count), 64'd0);
    chk("rst_enq_ready", 64'(iq.enq_ready), 64'd1);
    chk("rst_issue_uop", 64'(iq.issue_uop), 64'd0);

    // Single ready uop: visible at t+1, issued at t+2.
    u = mk(6'd1, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0);
    enq(u, 1'b0, 1'b0);
    sb.push_back(u);
    step();
    no_enq();
    chk("t1_valid_t1", 64'(iq.issue_uop.valid), 64'd0);
    chk("t1_count_t1", 64'(iq.count), 64'd1);
    step();
    chk("t1_valid_t2", 64'(iq.issue_uop.valid), 64'd1);
    chk("t1_count_t2", 64'(iq.count), 64'd0);
    chk("t1_enq_ready", 64'(iq.enq_ready), 64'd1);
    step();
    chk("t1_idle_valid", 64'(iq.issue_uop.valid), 64'd0);

    // Younger ready B overtakes older waiting A; A issues after wakeup.
    a = mk(6'd2, 1'b1, 7'd12, 1'b0, 7'd0, 1'b0, 7'd0);
    b = mk(6'd3, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0);
    enq(a, 1'b0, 1'b0);
    step();
    enq(b, 1'b0, 1'b0);
    sb.push_back(b);
    step();
    no_enq();
    chk("t2_none_ready", 64'(iq.issue_uop.valid), 64'd0);
    step();
    chk("t2_b_issued", 64'(iq.issue_uop.valid), 64'd1);
    chk("t2_count", 64'(iq.count), 64'd1);
    wb_set(0, 7'd12);
    sb.push_back(a);
    step();
    wb_clr();
    chk("t2_wake_cycle", 64'(iq.issue_uop.valid), 64'd0);
    step();
    chk("t2_a_issued", 64'(iq.issue_uop.valid), 64'd1);
    chk("t2_count_end", 64'(iq.count), 64'd0);

    // Fill to DEPTH, reject overflow, wake the middle entry, check collapse.
    for (int i = 0; i < 8; i++) begin
      fill[i] = mk(6'(10 + i), 1'b1, 7'(30 + i), 1'b0, 7'd0, 1'b0, 7'd0);
      enq(fill[i], 1'b0, 1'b0);
      step();
    end
    no_enq();
    chk("t3_full_count", 64'(iq.count), 64'd8);
    chk("t3_full_enq_ready", 64'(iq.enq_ready), 64'd0);
    enq(mk(6'd63, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b1, 1'b1);
    step();
    no_enq();
    chk("t3_overflow_rejected", 64'(iq.count), 64'd8);
    wb_set(0, 7'd33);
    sb.push_back(fill[3]);
    step();
    wb_clr();
    chk("t3_wake_count", 64'(iq.count), 64'd8);
    step();
    chk("t3_mid_issued", 64'(iq.issue_uop.valid), 64'd1);
    chk("t3_count_7", 64'(iq.count), 64'd7);
    chk("t3_enq_ready_back", 64'(iq.enq_ready), 64'd1);
    wb_set(0, 7'd37);
    sb.push_back(fill[7]);
    step();
    wb_clr();
    step();
    chk("t3_count_6", 64'(iq.count), 64'd6);
    wb_set(0, 7'd34);
    wb_set(1, 7'd30);
    sb.push_back(fill[0]);
    sb.push_back(fill[4]);
    step();
    wb_clr();
    step();
    step();
    chk("t3_count_4", 64'(iq.count), 64'd4);
    wb_set(0, 7'd31);
    wb_set(1, 7'd32);
    wb_set(2, 7'd35);
    wb_set(3, 7'd36);
    sb.push_back(fill[1]);
    sb.push_back(fill[2]);
    sb.push_back(fill[5]);
    sb.push_back(fill[6]);
    step();
    wb_clr();
    for (int i = 0; i < 4; i++) step();
    chk("t3_count_0", 64'(iq.count), 64'd0);
    chk("t3_drained", 64'(sb.size()), 64'd0);

    // Producer P then dependent D on P's destination.
    p = mk(6'd40, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 7'd20);
    d = mk(6'd41, 1'b1, 7'd20, 1'b0, 7'd0, 1'b0, 7'd0);
    enq(p, 1'b0, 1'b0);
    sb.push_back(p);
    step();
    enq(d, 1'b0, 1'b0);
    sb.push_back(d);
    step();
    no_enq();
    chk("t4_p_issued", 64'(iq.issue_uop.valid), 64'd1);
`ifdef ALU_IQ_BACK2BACK_EN
    step();
    chk("t4_d_back2back", 64'(iq.issue_uop.valid), 64'd1);
    chk("t4_count", 64'(iq.count), 64'd0);
`else
    step();
    chk("t4_d_waits", 64'(iq.issue_uop.valid), 64'd0);
    chk("t4_d_queued", 64'(iq.count), 64'd1);
    wb_set(0, 7'd20);
    step();
    wb_clr();
    chk("t4_d_wake_cycle", 64'(iq.issue_uop.valid), 64'd0);
    step();
    chk("t4_d_after_wb", 64'(iq.issue_uop.valid), 64'd1);
    chk("t4_count", 64'(iq.count), 64'd0);
`endif

    // Flush at count=5 with a ready entry selectable and an enqueue pending.
    for (int i = 0; i < 4; i++) begin
      enq(mk(6'(50 + i), 1'b1, 7'(60 + i), 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
      step();
    end
    enq(mk(6'd55, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    step();
    chk("t5_count_5", 64'(iq.count), 64'd5);
    enq(mk(6'd57, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    iq.flush = 1'b1;
    step();
    iq.flush = 1'b0;
    no_enq();
    chk("t5_flush_count", 64'(iq.count), 64'd0);
    chk("t5_flush_valid", 64'(iq.issue_uop.valid), 64'd0);
    step();
    chk("t5_enq_discarded", 64'(iq.count), 64'd0);
    for (int k = 0; k < 4; k++) wb_set(k, 7'(60 + k));
    step();
    wb_clr();
    step();
    chk("t5_entries_gone", 64'(iq.issue_uop.valid), 64'd0);

    // Stall holds the output for 3 cycles; enqueue+issue keeps count.
    enq(mk(6'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    sb.push_back(mk(6'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0));
    step();
    enq(mk(6'd21, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    step();
    chk("t6_first_issued", 64'(iq.issue_uop.valid), 64'd1);
    chk("t6_enq_issue_count", 64'(iq.count), 64'd1);
    iq.issue_stall = 1'b1;
    enq(mk(6'd22, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    step();
    no_enq();
    chk("t6_stall_count_a", 64'(iq.count), 64'd2);
    step();
    chk("t6_stall_count_b", 64'(iq.count), 64'd2);
    step();
    chk("t6_stall_count_c", 64'(iq.count), 64'd2);
    iq.issue_stall = 1'b0;
    sb.push_back(mk(6'd21, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0));
    sb.push_back(mk(6'd22, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0));
    step();
    chk("t6_release_issue", 64'(iq.issue_uop.valid), 64'd1);
    chk("t6_release_count", 64'(iq.count), 64'd1);
    step();
    chk("t6_second_issue", 64'(iq.issue_uop.valid), 64'd1);
    chk("t6_empty", 64'(iq.count), 64'd0);

    // Flush wins over a concurrent stall.
    enq(mk(6'd23, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0), 1'b0, 1'b0);
    step();
    no_enq();
    chk("t6_one_queued", 64'(iq.count), 64'd1);
    iq.issue_stall = 1'b1;
    iq.flush       = 1'b1;
    step();
    iq.issue_stall = 1'b0;
    iq.flush       = 1'b0;
    chk("t6_flush_stall_count", 64'(iq.count), 64'd0);
    chk("t6_flush_stall_valid", 64'(iq.issue_uop.valid), 64'd0);
    step();
    chk("t6_post_flush_valid", 64'(iq.issue_uop.valid), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
